// File: rtl/mem_controller_pkg.sv
// Shared request codes and state encodings for the core_control / mem_controller handshake.
package mem_controller_pkg;

  localparam logic [2:0] COND_NONE  = 3'b000;
  localparam logic [2:0] COND_INPUT = 3'b100;
  localparam logic [2:0] COND_MEM   = 3'b010;
  localparam logic [2:0] COND_REG   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } mc_state_e;

  function automatic logic cond_illegal(input logic [2:0] c);
    return !((c == COND_NONE) || (c == COND_INPUT) || (c == COND_MEM) || (c == COND_REG));
  endfunction

endpackage

// File: rtl/mc_sram.sv
// Single-port DEPTH x DATA_W memory: synchronous write, one-cycle registered read, no reset.
module mc_sram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              mc_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge mc_clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_controller.sv
// Responder side of the request/mc_done handshake: stores an input burst into local
// memory and moves it into the processing unit's register bank in REG_WORDS chunks.
//
// state    | meaning
// ST_IDLE  | waiting for a request code
// ST_STORE | accepting input words into memory
// ST_READ  | issuing reads and capturing words into register lanes
// ST_DONE  | request finished; wait for the code to change
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int REG_WORDS = 4
) (
  input  logic                          mc_clk,
  input  logic                          mc_reset,
  input  logic [2:0]                    mc_data_contition,
  input  logic [ADDR_W:0]               mc_data_length,
  input  logic [DATA_W-1:0]             mc_data_in,
  input  logic                          mc_data_in_valid,
  output logic                          mc_data_in_ready,
  output logic                          mc_done,
  output logic                          mc_data_done,
  output logic [REG_WORDS*DATA_W-1:0]   mc_reg_data,
  output logic [REG_WORDS-1:0]          mc_reg_valid,
  output logic                          mc_illegal
);

  localparam int PW = ADDR_W + 1;
  localparam int LW = $clog2(REG_WORDS + 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(2**ADDR_W);
  localparam logic [PW-1:0] REG_WORDS_P = PW'(REG_WORDS);

  mc_state_e           state, state_nxt;
  logic [PW-1:0]       len, wr_ptr, rd_ptr;
  logic [PW-1:0]       len_in, remain, len_m1;
  logic [2:0]          req_code;
  logic [LW-1:0]       rd_cnt, lane, n_words;
  logic                done_seen, illegal_q, data_done_q;
  logic                sram_we;
  logic [ADDR_W-1:0]   sram_addr;
  logic [DATA_W-1:0]   sram_rdata;

  assign len_in  = (mc_data_length > DEPTH_P) ? DEPTH_P : mc_data_length;
  assign remain  = len - rd_ptr;
  assign n_words = (remain > REG_WORDS_P) ? LW'(REG_WORDS) : remain[LW-1:0];
  assign len_m1  = len - 1'b1;
  assign lane    = rd_cnt - 1'b1;

  always_ff @(posedge mc_clk) begin
    if (mc_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mc_data_contition == COND_INPUT)
          state_nxt = (len_in == '0) ? ST_DONE : ST_STORE;
        else if (mc_data_contition == COND_MEM)
          state_nxt = ST_READ;
      end
      ST_STORE: begin
        if (mc_data_contition == COND_NONE)            state_nxt = ST_IDLE;
        else if (mc_data_in_valid && wr_ptr == len_m1) state_nxt = ST_DONE;
      end
      ST_READ: begin
        if (mc_data_contition == COND_NONE) state_nxt = ST_IDLE;
        else if (rd_cnt == n_words)         state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (mc_data_contition != req_code) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mc_data_in_ready = (state == ST_STORE);
    mc_done          = (state == ST_DONE) && !done_seen;
    sram_we          = (state == ST_STORE) && mc_data_in_valid;
    sram_addr        = (state == ST_STORE) ? wr_ptr[ADDR_W-1:0]
                                           : rd_ptr[ADDR_W-1:0] + ADDR_W'(rd_cnt);
  end

  assign mc_illegal   = illegal_q;
  assign mc_data_done = data_done_q;

  // rd_cnt counts issue slots; the word issued in slot k lands in lane k one cycle later.
  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      len          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_cnt       <= '0;
      req_code     <= COND_NONE;
      done_seen    <= 1'b0;
      illegal_q    <= 1'b0;
      data_done_q  <= 1'b1;
      mc_reg_data  <= '0;
      mc_reg_valid <= '0;
    end else begin
      done_seen <= (state == ST_DONE);
      illegal_q <= (state == ST_IDLE) && cond_illegal(mc_data_contition);
      case (state)
        ST_IDLE: begin
          if (mc_data_contition == COND_INPUT) begin
            len         <= len_in;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            req_code    <= mc_data_contition;
            data_done_q <= (len_in == '0);
          end else if (mc_data_contition == COND_MEM) begin
            mc_reg_data  <= '0;
            mc_reg_valid <= '0;
            rd_cnt       <= '0;
            req_code     <= mc_data_contition;
          end
        end
        ST_STORE: begin
          if (mc_data_in_valid) wr_ptr <= wr_ptr + 1'b1;
        end
        ST_READ: begin
          for (int k = 0; k < REG_WORDS; k++) begin
            if (rd_cnt != '0 && lane == LW'(k)) begin
              mc_reg_data[k*DATA_W +: DATA_W] <= sram_rdata;
              mc_reg_valid[k]                 <= 1'b1;
            end
          end
          if (mc_data_contition != COND_NONE) begin
            if (rd_cnt == n_words) begin
              rd_ptr      <= rd_ptr + PW'(n_words);
              data_done_q <= ((rd_ptr + PW'(n_words)) == len);
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  mc_sram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .mc_clk (mc_clk),
    .we     (sram_we),
    .addr   (sram_addr),
    .wdata  (mc_data_in),
    .rdata  (sram_rdata)
  );

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: store bursts, chunked reads, handshake blocking, clamp, illegal code, reset.
module tb_mem_controller;
  import mem_controller_pkg::*;

  logic        mc_clk = 1'b0;
  logic        mc_reset;
  logic [2:0]  cond;
  logic [6:0]  length;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        done;
  logic        data_done;
  logic [31:0] reg_data;
  logic [3:0]  reg_valid;
  logic        illegal;

  int n_chk = 0;
  int n_err = 0;

  mem_controller #(.DATA_W(8), .ADDR_W(6), .REG_WORDS(4)) dut (
    .mc_clk            (mc_clk),
    .mc_reset          (mc_reset),
    .mc_data_contition (cond),
    .mc_data_length    (length),
    .mc_data_in        (din),
    .mc_data_in_valid  (din_valid),
    .mc_data_in_ready  (din_ready),
    .mc_done           (done),
    .mc_data_done      (data_done),
    .mc_reg_data       (reg_data),
    .mc_reg_valid      (reg_valid),
    .mc_illegal        (illegal)
  );

  always #5 mc_clk = ~mc_clk;

  task automatic tick();
    @(posedge mc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts from any state by dropping to 000 first; n_exp is the post-clamp word count (>0).
  task automatic do_store(input logic [6:0] len_req, input int n_exp, input logic [7:0] base,
                          input bit gap);
    int  acc;
    int  cyc;
    acc = 0;
    cyc = 0;
    cond = COND_NONE;
    din_valid = 1'b0;
    tick();
    cond = COND_INPUT;
    length = len_req;
    tick();
    check("store_ready", din_ready, 1);
    while (acc < n_exp && cyc < 300) begin
      din_valid = !(gap && (cyc % 2 == 1));
      din = din_valid ? 8'(base + acc) : 8'hEE;
      if (din_valid && acc == n_exp - 1) check("store_no_early_done", done, 0);
      tick();
      if (din_valid) acc++;
      cyc++;
    end
    din_valid = 1'b1;
    din = 8'hEE;
    check("store_accepts", acc, n_exp);
    check("store_done", done, 1);
    check("store_ready_low", din_ready, 0);
    tick();
    din_valid = 1'b0;
    check("store_done_pulse", done, 0);
  endtask

  task automatic do_read(input bit direct, input int n, input logic [31:0] exp_data,
                         input logic [3:0] exp_valid, input bit exp_dd);
    if (direct) begin
      cond = COND_MEM;
      tick();
    end else begin
      cond = COND_REG;
      tick();
      cond = COND_MEM;
    end
    for (int i = 0; i < n + 1; i++) tick();
    check("read_no_early_done", done, 0);
    tick();
    check("read_done", done, 1);
    check("read_data", reg_data, exp_data);
    check("read_valid", reg_valid, exp_valid);
    check("read_data_done", data_done, exp_dd);
    tick();
    check("read_done_pulse", done, 0);
  endtask

  initial begin
    mc_reset = 1'b1;
    cond = COND_NONE;
    length = '0;
    din = '0;
    din_valid = 1'b0;
    tick();
    tick();
    mc_reset = 1'b0;
    check("rst_ready", din_ready, 0);
    check("rst_done", done, 0);
    check("rst_data_done", data_done, 1);
    check("rst_reg_data", reg_data, 0);
    check("rst_reg_valid", reg_valid, 0);
    check("rst_illegal", illegal, 0);

    // store 6 words, then two chunked reads
    do_store(7'd6, 6, 8'h11, 1'b0);
    check("t1_data_done", data_done, 0);
    do_read(1'b0, 4, 32'h1413_1211, 4'b1111, 1'b0);
    do_read(1'b0, 2, 32'h0000_1615, 4'b0011, 1'b1);

    // held 100 must not retrigger; then 100 -> 010 directly
    do_store(7'd3, 3, 8'h21, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_no_done", done, 0);
      check("t3_hold_no_ready", din_ready, 0);
    end
    do_read(1'b1, 3, 32'h0023_2221, 4'b0111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_read_hold_no_done", done, 0);
      check("t3_read_hold_valid", reg_valid, 4'b0111);
    end

    // zero-length store and empty read
    cond = COND_NONE;
    tick();
    cond = COND_INPUT;
    length = 7'd0;
    tick();
    check("t4_done", done, 1);
    check("t4_data_done", data_done, 1);
    check("t4_ready", din_ready, 0);
    do_read(1'b0, 0, 32'h0, 4'b0000, 1'b1);

    // gapped store, then clamp of 100 to 64
    do_store(7'd4, 4, 8'h31, 1'b1);
    check("t5_data_done", data_done, 0);
    do_read(1'b0, 4, 32'h3433_3231, 4'b1111, 1'b1);
    do_store(7'd100, 64, 8'h40, 1'b0);
    check("t5_clamp_data_done", data_done, 0);

    // illegal code in IDLE
    cond = COND_NONE;
    tick();
    cond = 3'b110;
    tick();
    check("t6_illegal", illegal, 1);
    check("t6_illegal_no_ready", din_ready, 0);
    cond = COND_NONE;
    tick();
    check("t6_illegal_pulse", illegal, 0);
    do_read(1'b0, 4, 32'h4342_4140, 4'b1111, 1'b0);

    // reset in the middle of a read
    cond = COND_REG;
    tick();
    cond = COND_MEM;
    tick();
    tick();
    mc_reset = 1'b1;
    cond = COND_NONE;
    tick();
    mc_reset = 1'b0;
    check("t6_rst_done", done, 0);
    check("t6_rst_data_done", data_done, 1);
    check("t6_rst_reg_data", reg_data, 0);
    check("t6_rst_reg_valid", reg_valid, 0);
    check("t6_rst_ready", din_ready, 0);
    check("t6_rst_illegal", illegal, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_rst_no_done", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
